conv_encoder_framed: RTL and testbench

//  Rate-1/2 convolutional encoder; the transmit-side counterpart of the Viterbi decoder datapath.

---
 rtl/conv_encoder_framed.sv | 179 +++++++++++++++++
 tb/tb_conv_encoder_framed.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder_framed.sv
// ---------------------------------------------------------------------------
// conv_encoder_framed
//
// Rate-1/2 convolutional encoder with framing. Serial data bits come in over
// a valid/ready port. Each accepted bit is encoded into one 2-bit code pair.
// After every FRAME_LEN data bits the encoder appends K-1 zero tail bits so
// that the trellis is back in state 0 at each frame boundary.
//
// Handshake: a transfer happens on a rising clk edge where valid & ready are
// both high. The producer holds data stable while valid & !ready, and valid is
// never withdrawn on account of ready. The same rule applies to the input port
// (in_valid/in_ready) and to the output port (out_valid/out_ready).
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous, active-high reset
//   in_valid   in   1   in_bit is valid
//   in_bit     in   1   data bit, taken when in_valid & in_ready
//   in_ready   out  1   encoder can take a data bit this cycle
//   out_valid  out  1   out_pair / out_last are valid
//   out_pair   out  2   [1]=parity(G0 & taps), [0]=parity(G1 & taps)
//   out_last   out  1   marks the final tail pair of a frame
//   out_ready  in   1   downstream takes the pair when out_valid & out_ready
//   busy       out  1   high in DATA or TAIL
//   state_dbg  out  2   FSM state: 0=IDLE, 1=DATA, 2=TAIL
// ---------------------------------------------------------------------------
module conv_encoder_framed #(
    parameter int             K         = 3,
    parameter logic [K-1:0]   G0        = 3'b111,
    parameter logic [K-1:0]   G1        = 3'b101,
    parameter int             FRAME_LEN = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic       out_valid,
    output logic [1:0] out_pair,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy,
    output logic [1:0] state_dbg
);

    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam int TW = $clog2(K);
    localparam logic [CW-1:0] LAST_BIT  = CW'(FRAME_LEN - 1);
    localparam logic [TW-1:0] LAST_TAIL = TW'(K - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_TAIL = 2'd2
    } state_t;

    state_t          state_q,     state_d;
    logic [K-2:0]    sr_q,        sr_d;
    logic [CW-1:0]   bit_cnt_q,   bit_cnt_d;
    logic [TW-1:0]   tail_cnt_q,  tail_cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [1:0]      out_pair_q,  out_pair_d;
    logic            out_last_q,  out_last_d;

    logic            load_ok;
    logic            accept;
    logic            tail_load;
    logic            load;
    logic            enc_bit;
    logic [K-1:0]    tap;
    logic [K-2:0]    sr_shift;

    // The output register can take a new pair when it is empty or is being
    // drained in this same cycle (replace without a bubble).
    assign load_ok   = !out_valid_q || out_ready;
    assign in_ready  = (state_q != S_TAIL) && load_ok;
    assign accept    = in_valid && in_ready;
    assign tail_load = (state_q == S_TAIL) && load_ok;
    assign load      = accept || tail_load;
    // Tail cycles feed zeros; they never consume input.
    assign enc_bit   = accept ? in_bit : 1'b0;

    // Tap vector {b, sr[0], ..., sr[K-2]} and the shifted register.
    always_comb begin
        tap        = '0;
        tap[K-1]   = enc_bit;
        for (int i = 0; i < K - 1; i++) begin
            tap[K-2-i] = sr_q[i];
        end
        sr_shift    = '0;
        sr_shift[0] = enc_bit;
        for (int i = 1; i < K - 1; i++) begin
            sr_shift[i] = sr_q[i-1];
        end
    end

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        tail_cnt_d  = tail_cnt_q;
        out_valid_d = out_valid_q;
        out_pair_d  = out_pair_q;
        out_last_d  = out_last_q;

        if (load) begin
            out_valid_d = 1'b1;
            out_pair_d  = {^(G0 & tap), ^(G1 & tap)};
            out_last_d  = tail_load && (tail_cnt_q == LAST_TAIL);
            sr_d        = sr_shift;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (FRAME_LEN == 1) begin
                        state_d = S_TAIL;
                    end else begin
                        bit_cnt_d = CW'(1);
                        state_d   = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = S_TAIL;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
            end
            S_TAIL: begin
                if (tail_load) begin
                    if (tail_cnt_q == LAST_TAIL) begin
                        tail_cnt_d = '0;
                        state_d    = S_IDLE;
                    end else begin
                        tail_cnt_d = tail_cnt_q + TW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            tail_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_pair_q  <= 2'b00;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            tail_cnt_q  <= tail_cnt_d;
            out_valid_q <= out_valid_d;
            out_pair_q  <= out_pair_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pair  = out_pair_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != S_IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_conv_encoder_framed.sv
// ---------------------------------------------------------------------------
// tb_conv_encoder_framed
//
// Bench for conv_encoder_framed. Main instance uses FRAME_LEN=4, a second
// instance uses FRAME_LEN=1. Expected code pairs come from a direct
// convolution of the frame bits (data followed by K-1 zeros) with the
// generator polynomials, or from fixed tables for the hand-worked cases.
// ---------------------------------------------------------------------------
module tb_conv_encoder_framed;

    localparam int           K  = 3;
    localparam int           FL = 4;
    localparam logic [K-1:0] G0 = 3'b111;
    localparam logic [K-1:0] G1 = 3'b101;
    localparam int           WAIT_MAX = 200;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // main instance signals
    logic       in_valid  = 1'b0;
    logic       in_bit    = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [1:0] out_pair;
    logic       out_last;
    logic       out_ready = 1'b1;
    logic       busy;
    logic [1:0] state_dbg;

    // FRAME_LEN=1 instance signals
    logic       v1_in_valid  = 1'b0;
    logic       v1_in_bit    = 1'b0;
    logic       v1_in_ready;
    logic       v1_out_valid;
    logic [1:0] v1_out_pair;
    logic       v1_out_last;
    logic       v1_out_ready = 1'b1;
    logic       v1_busy;
    logic [1:0] v1_state;

    conv_encoder_framed #(.K(K), .G0(G0), .G1(G1), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
        .out_valid(out_valid), .out_pair(out_pair), .out_last(out_last),
        .out_ready(out_ready), .busy(busy), .state_dbg(state_dbg)
    );

    conv_encoder_framed #(.K(K), .G0(G0), .G1(G1), .FRAME_LEN(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(v1_in_valid), .in_bit(v1_in_bit), .in_ready(v1_in_ready),
        .out_valid(v1_out_valid), .out_pair(v1_out_pair), .out_last(v1_out_last),
        .out_ready(v1_out_ready), .busy(v1_busy), .state_dbg(v1_state)
    );

    int total = 0;
    int bad   = 0;

    // scoreboard: {out_last, out_pair}
    logic [2:0] exp_q[$];
    logic [2:0] got_q[$];
    int         got_t[$];

    // collector: every pair handed downstream, with the cycle it was taken
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            got_q.push_back({out_last, out_pair});
            got_t.push_back(cyc);
        end
    end

    // reference: pair for history hist[d] = bit d steps in the past
    function automatic logic [1:0] ref_pair(input logic [K-1:0] hist);
        int a;
        int c;
        logic [1:0] p;
        a = 0;
        c = 0;
        for (int d = 0; d < K; d++) begin
            a += int'(G0[K-1-d] & hist[d]);
            c += int'(G1[K-1-d] & hist[d]);
        end
        p[1] = (a % 2) == 1;
        p[0] = (c % 2) == 1;
        return p;
    endfunction

    // append the expected pairs for one frame (bits[i] = i-th bit sent)
    function automatic void add_frame(input logic [31:0] bits, input int n);
        logic seq[$];
        logic [K-1:0] hist;
        for (int i = 0; i < n; i++) seq.push_back(bits[i]);
        for (int i = 0; i < K - 1; i++) seq.push_back(1'b0);
        for (int j = 0; j < seq.size(); j++) begin
            for (int d = 0; d < K; d++) hist[d] = (j - d >= 0) ? seq[j-d] : 1'b0;
            exp_q.push_back({j == seq.size() - 1, ref_pair(hist)});
        end
    endfunction

    // driver: send n bits with optional idle gaps; starts and ends at posedge+#1
    task automatic drive_bits(input logic [31:0] bits, input int n, input int idle_pct);
        int waited;
        int idle;
        for (int i = 0; i < n; i++) begin
            idle = ($urandom_range(0, 99) < idle_pct) ? $urandom_range(1, 3) : 0;
            for (int g = 0; g < idle; g++) begin
                in_valid = 1'b0;
                in_bit   = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_bit   = bits[i];
            waited   = 0;
            forever begin
                @(negedge clk);
                if (in_ready) break;
                waited++;
                if (waited > WAIT_MAX) break;
            end
            if (waited > WAIT_MAX) begin
                total++; bad++;
                $display("FAIL drive_timeout bit=%0d in_ready stuck low for %0d cycles", i, waited);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int n);
        for (int c = 0; c < WAIT_MAX && got_q.size() < n; c++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_pair !== 2'b00) begin bad++; $display("FAIL reset_out_pair got=%b want=00", out_pair); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b want=0", out_last); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state_dbg); end
    endtask

    task automatic test_basic();
        logic [2:0] t1[6] = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
        got_q.delete(); got_t.delete();
        drive_bits(32'b1101, 4, 0);
        wait_drain(6);
        total++;
        if (got_q.size() !== 6) begin bad++; $display("FAIL basic_count got=%0d want=6", got_q.size()); end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== t1[i]) begin bad++; $display("FAIL basic_pair[%0d] got=%b want=%b", i, got_q[i], t1[i]); end
        end
        for (int i = 1; i < 6 && i < got_t.size(); i++) begin
            total++;
            if (got_t[i] !== got_t[0] + i) begin bad++; $display("FAIL basic_gap[%0d] got_cycle=%0d want=%0d", i, got_t[i], got_t[0] + i); end
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] t1[6] = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
        got_q.delete(); got_t.delete();
        fork
            drive_bits(32'b1101, 4, 0);
            begin
                for (int c = 0; c < WAIT_MAX; c++) begin
                    @(posedge clk); #1;
                    if (got_q.size() >= 1) break;
                end
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b want=1", out_valid); end
                    total++; if ({out_last, out_pair} !== 3'b010) begin bad++; $display("FAIL bp_hold got=%b want=010", {out_last, out_pair}); end
                    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain(6);
        total++;
        if (got_q.size() !== 6) begin bad++; $display("FAIL bp_count got=%0d want=6", got_q.size()); end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== t1[i]) begin bad++; $display("FAIL bp_pair[%0d] got=%b want=%b", i, got_q[i], t1[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] f1;
        logic [31:0] f2;
        int          stall_cnt;
        bit          drv_done;
        f1 = 32'($urandom_range(0, 15));
        f2 = 32'($urandom_range(0, 15));
        got_q.delete(); got_t.delete(); exp_q.delete();
        add_frame(f1, FL);
        add_frame(f2, FL);
        stall_cnt = 0;
        drv_done  = 1'b0;
        fork
            begin
                drive_bits(f1 | (f2 << FL), 2 * FL, 0);
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(negedge clk);
                    if (in_valid && !in_ready) stall_cnt++;
                end
            end
        join
        wait_drain(exp_q.size());
        total++;
        if (stall_cnt !== K - 1) begin bad++; $display("FAIL b2b_gap got=%0d want=%0d", stall_cnt, K - 1); end
        total++;
        if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_pair[%0d] got=%b want=%b", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [2:0] t1[6] = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
        drive_bits(32'b11, 2, 0);
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%b want=0", out_valid); end
        total++; if (out_pair !== 2'b00) begin bad++; $display("FAIL rstmid_out_pair got=%b want=00", out_pair); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL rstmid_out_last got=%b want=0", out_last); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        got_q.delete(); got_t.delete();
        drive_bits(32'b1101, 4, 0);
        wait_drain(6);
        total++;
        if (got_q.size() !== 6) begin bad++; $display("FAIL rstmid_count got=%0d want=6", got_q.size()); end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== t1[i]) begin bad++; $display("FAIL rstmid_pair[%0d] got=%b want=%b", i, got_q[i], t1[i]); end
        end
    endtask

    task automatic test_random();
        localparam int NF = 8;
        logic [FL-1:0] sent[NF];
        logic [FL-1:0] rec;
        logic          dec_seq[$];
        logic [K-1:0]  hist;
        logic [2:0]    prev;
        bit            prev_stall;
        bit            done;
        logic          found;
        int            per;
        got_q.delete(); got_t.delete(); exp_q.delete();
        for (int f = 0; f < NF; f++) begin
            sent[f] = FL'($urandom_range(0, (1 << FL) - 1));
            add_frame(32'(sent[f]), FL);
        end
        done       = 1'b0;
        prev_stall = 1'b0;
        prev       = '0;
        fork
            begin
                for (int f = 0; f < NF; f++) drive_bits(32'(sent[f]), FL, 30);
                for (int c = 0; c < WAIT_MAX && got_q.size() < exp_q.size(); c++) @(posedge clk);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    if (prev_stall) begin
                        total++;
                        if (!out_valid || {out_last, out_pair} !== prev) begin
                            bad++; $display("FAIL rand_hold got=%b/%b want=1/%b", out_valid, {out_last, out_pair}, prev);
                        end
                    end
                    prev_stall = out_valid && !out_ready;
                    prev       = {out_last, out_pair};
                end
            end
        join
        wait_drain(exp_q.size());
        total++;
        if (got_q.size() !== NF * (FL + K - 1)) begin bad++; $display("FAIL rand_count got=%0d want=%0d", got_q.size(), NF * (FL + K - 1)); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_pair[%0d] got=%b want=%b", i, got_q[i], exp_q[i]); end
        end
        // loopback: recover each bit by finding the input that reproduces the pair
        per = FL + K - 1;
        for (int f = 0; f < NF; f++) begin
            dec_seq.delete();
            rec = '0;
            for (int j = 0; j < per && f * per + j < got_q.size(); j++) begin
                found = 1'b0;
                for (int cand = 0; cand < 2; cand++) begin
                    hist[0] = 1'(cand);
                    for (int d = 1; d < K; d++) hist[d] = (j - d >= 0) ? dec_seq[j-d] : 1'b0;
                    if (!found && ref_pair(hist) == got_q[f*per+j][1:0]) begin
                        dec_seq.push_back(1'(cand));
                        found = 1'b1;
                    end
                end
                if (!found) dec_seq.push_back(1'b0);
                if (j < FL) rec[j] = dec_seq[j];
            end
            total++;
            if (rec !== sent[f]) begin bad++; $display("FAIL rand_loopback[%0d] got=%b want=%b", f, rec, sent[f]); end
        end
    endtask

    task automatic test_frame_len1();
        v1_in_valid = 1'b1;
        v1_in_bit   = 1'b1;
        @(negedge clk);
        total++; if (v1_in_ready !== 1'b1) begin bad++; $display("FAIL fl1_in_ready got=%b want=1", v1_in_ready); end
        @(posedge clk); #1;
        v1_in_valid = 1'b0;
        total++; if (v1_state !== 2'd2) begin bad++; $display("FAIL fl1_state0 got=%0d want=2", v1_state); end
        total++; if ({v1_out_valid, v1_out_last, v1_out_pair} !== 4'b1011) begin bad++; $display("FAIL fl1_pair0 got=%b want=1011", {v1_out_valid, v1_out_last, v1_out_pair}); end
        total++; if (v1_in_ready !== 1'b0) begin bad++; $display("FAIL fl1_tail_ready got=%b want=0", v1_in_ready); end
        @(posedge clk); #1;
        total++; if (v1_state !== 2'd2) begin bad++; $display("FAIL fl1_state1 got=%0d want=2", v1_state); end
        total++; if ({v1_out_valid, v1_out_last, v1_out_pair} !== 4'b1010) begin bad++; $display("FAIL fl1_pair1 got=%b want=1010", {v1_out_valid, v1_out_last, v1_out_pair}); end
        @(posedge clk); #1;
        total++; if (v1_state !== 2'd0) begin bad++; $display("FAIL fl1_state2 got=%0d want=0", v1_state); end
        total++; if ({v1_out_valid, v1_out_last, v1_out_pair} !== 4'b1111) begin bad++; $display("FAIL fl1_pair2 got=%b want=1111", {v1_out_valid, v1_out_last, v1_out_pair}); end
        total++; if (v1_busy !== 1'b0) begin bad++; $display("FAIL fl1_busy got=%b want=0", v1_busy); end
        @(posedge clk); #1;
        total++; if (v1_out_valid !== 1'b0) begin bad++; $display("FAIL fl1_drain got=%b want=0", v1_out_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        test_frame_len1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
